// File: rtl/int_to_fp.sv
// int_to_fp: 3-stage pipelined signed 32-bit integer to IEEE-754 binary32 converter
module int_to_fp (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] int_val,
  output logic [31:0] fp
);
  logic        s1_sign, s1_zero;
  logic [31:0] s1_mag;
  logic        s2_sign, s2_zero;
  logic [31:0] s2_shift;
  logic [4:0]  s2_exp;
  logic [4:0]  lz_pos;
  logic        inc;
  logic [23:0] rnd;
  logic [7:0]  bexp;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sign <= 1'b0;
      s1_zero <= 1'b1;
      s1_mag  <= '0;
    end else begin
      s1_sign <= int_val[31];
      s1_zero <= int_val == '0;
      s1_mag  <= int_val[31] ? -int_val : int_val;
    end
  end
  always_comb begin
    lz_pos = '0;
    for (int i = 0; i < 32; i++) lz_pos = s1_mag[i] ? 5'(i) : lz_pos;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b1;
      s2_shift <= '0;
      s2_exp   <= '0;
    end else begin
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_shift <= s1_mag << (5'd31 - lz_pos);
      s2_exp   <= lz_pos;
    end
  end
  always_comb begin
    inc  = s2_shift[7] & ((|s2_shift[6:0]) | s2_shift[8]);
    rnd  = {1'b0, s2_shift[30:8]} + 24'(inc);
    bexp = 8'd127 + {3'b0, s2_exp} + 8'(rnd[23]);
  end
  always_ff @(posedge clk) begin
    if (reset) fp <= '0;
    else fp <= s2_zero ? 32'h0 : {s2_sign, bexp, rnd[22:0]};
  end
endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp: scoreboard bench for int_to_fp with directed and random operands
module tb_int_to_fp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] int_val = '0;
  logic [31:0] fp;
  logic        use_dir = 1'b0;
  logic [31:0] dir_exp = '0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  int_to_fp dut (.clk(clk), .reset(reset), .int_val(int_val), .fp(fp));

  function automatic logic [31:0] ref_cvt(input logic [31:0] x);
    longint v, m, q, r, half;
    int e, sh;
    v = longint'(signed'(x));
    m = v < 0 ? -v : v;
    if (m == 0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) q = m << (23 - e);
    else begin
      sh = e - 23;
      q = m >> sh;
      r = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {x[31], 8'(e + 127), q[22:0]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      repeat (3) exp_q.push_back(32'h0);
    end else exp_q.push_back(use_dir ? dir_exp : ref_cvt(int_val));
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      n_cmp++;
      if (fp !== mon_exp) begin
        n_fail++;
        $display("FAIL fp at %0t: got %h expected %h", $time, fp, mon_exp);
      end
    end
  end

  task automatic drive(input logic [31:0] x, input logic r, input logic d, input logic [31:0] ex);
    @(negedge clk);
    int_val = x;
    reset = r;
    use_dir = d;
    dir_exp = ex;
  endtask

  initial begin
    logic [31:0] x;
    repeat (4) drive(32'hFFFF_F884, 1'b1, 1'b0, 32'h0);
    if (fp !== 32'h0) begin
      n_fail++;
      $display("FAIL reset state: fp=%h expected 00000000", fp);
    end
    drive(32'hFFFF_F884, 1'b0, 1'b1, 32'hC4EF_8000);
    drive(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000);
    drive(32'h0000_0001, 1'b0, 1'b1, 32'h3F80_0000);
    drive(32'hFFFF_FFFF, 1'b0, 1'b1, 32'hBF80_0000);
    drive(32'h7FFF_FFFF, 1'b0, 1'b1, 32'h4F00_0000);
    drive(32'h8000_0000, 1'b0, 1'b1, 32'hCF00_0000);
    drive(32'h0100_0001, 1'b0, 1'b1, 32'h4B80_0000);
    drive(32'h0100_0003, 1'b0, 1'b1, 32'h4B80_0002);
    drive(32'h0100_0005, 1'b0, 1'b1, 32'h4B80_0002);
    drive(32'hFEFF_FFFD, 1'b0, 1'b1, 32'hCB80_0002);
    drive(32'h00FF_FFFF, 1'b0, 1'b1, 32'h4B7F_FFFF);
    drive(32'h1234_5678, 1'b0, 1'b0, 32'h0);
    drive(32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
    drive(32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    drive(32'h5555_5555, 1'b1, 1'b0, 32'h0);
    drive(32'h0000_0064, 1'b0, 1'b1, 32'h42C8_0000);
    drive(32'hFFFF_FF9C, 1'b0, 1'b1, 32'hC2C8_0000);
    for (int i = 0; i < 10000; i++) begin
      x = $urandom;
      if (i % 3 == 0) x = x >> $urandom_range(0, 31);
      if (i % 6 == 0) x = -x;
      drive(x, 1'b0, 1'b0, 32'h0);
    end
    repeat (4) drive(32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    if (n_cmp < 10020) begin
      n_fail++;
      $display("FAIL wait expired: only %0d outputs compared", n_cmp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
